// File: rtl/reorder_buffer.sv
// In-order retirement buffer for the dual-issue core: 16 entries indexed by ageTag, two retirements per cycle.
// Optional sticky protocolError output when ROB_PROTOCOL_CHECK_EN is defined.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [42:0]      issuedUpper,
  input  logic [42:0]      issuedLower,
  input  logic [36:0]      writebackUpper,
  input  logic [36:0]      writebackLower,
  input  logic [36:0]      writebackMemory,
  input  logic             storeCommitReady,
  output logic [37:0]      retiredUpper,
  output logic [37:0]      retiredLower,
  output logic             storeCommit,
  output logic [TAG_W-1:0] storeCommitTag,
  output logic [TAG_W-1:0] nextAgeTag,
  output logic [TAG_W:0]   freeEntries
`ifdef ROB_PROTOCOL_CHECK_EN
  ,
  output logic             protocolError
`endif
);

  // Payloads: issued = {pc[31:0], dest[4:0], ageTag[3:0], isStore, confirm}
  //           writeback = {result[31:0], ageTag[3:0], valid}; retired = {result[31:0], dest[4:0], valid}
  logic             upConfirm, loConfirm, upStore, loStore;
  logic [TAG_W-1:0] upTag, loTag;
  logic [4:0]       upDest, loDest;
  logic [31:0]      upPc, loPc;

  assign upConfirm = issuedUpper[0];
  assign upStore   = issuedUpper[1];
  assign upTag     = issuedUpper[5:2];
  assign upDest    = issuedUpper[10:6];
  assign upPc      = issuedUpper[42:11];
  assign loConfirm = issuedLower[0];
  assign loStore   = issuedLower[1];
  assign loTag     = issuedLower[5:2];
  assign loDest    = issuedLower[10:6];
  assign loPc      = issuedLower[42:11];

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;

  logic             entryValid  [DEPTH];
  logic             entryReady  [DEPTH];
  logic             entryStore  [DEPTH];
  logic [TAG_W-1:0] entryTag    [DEPTH];
  logic [4:0]       entryDest   [DEPTH];
  logic [31:0]      entryPc     [DEPTH];
  logic [31:0]      entryResult [DEPTH];

  // Index order sets write priority: memory (last) wins over upper over lower.
  logic [36:0] writebacks [3];
  assign writebacks[0] = writebackLower;
  assign writebacks[1] = writebackUpper;
  assign writebacks[2] = writebackMemory;

  logic             retireUpper, retireLower, acceptUpper, acceptLower;
  logic [TAG_W-1:0] headNext, lowerSlot;
  logic [TAG_W:0]   allocCount, retireCount;

  assign freeEntries = (TAG_W+1)'(DEPTH) - count;
  assign nextAgeTag  = tail;

  always_comb begin
    headNext    = head + 1'b1;
    retireUpper = entryValid[head] && entryReady[head] && (!entryStore[head] || storeCommitReady);
    retireLower = retireUpper && entryValid[headNext] && entryReady[headNext]
                  && !entryStore[headNext] && (count >= (TAG_W+1)'(2));
    acceptUpper = upConfirm && (freeEntries != '0);
    acceptLower = loConfirm && (freeEntries > (TAG_W+1)'(acceptUpper));
    lowerSlot   = tail + TAG_W'(acceptUpper);
    allocCount  = (TAG_W+1)'(acceptUpper) + (TAG_W+1)'(acceptLower);
    retireCount = (TAG_W+1)'(retireUpper) + (TAG_W+1)'(retireLower);
  end

  function automatic logic [37:0] retirePayload(input logic isStore, input logic [4:0] dest,
                                                input logic [31:0] result);
    if (isStore || dest == '0) return '0;
    return {result, dest, 1'b1};
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      retiredUpper   <= '0;
      retiredLower   <= '0;
      storeCommit    <= 1'b0;
      storeCommitTag <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryValid[i]  <= 1'b0;
        entryReady[i]  <= 1'b0;
        entryStore[i]  <= 1'b0;
        entryTag[i]    <= '0;
        entryDest[i]   <= '0;
        entryPc[i]     <= '0;
        entryResult[i] <= '0;
      end
    end else if (flush) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      retiredUpper   <= '0;
      retiredLower   <= '0;
      storeCommit    <= 1'b0;
      storeCommitTag <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryValid[i] <= 1'b0;
        entryReady[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (writebacks[i][0] && entryValid[writebacks[i][4:1]]) begin
          entryReady[writebacks[i][4:1]] <= 1'b1;
          if (!entryStore[writebacks[i][4:1]]) entryResult[writebacks[i][4:1]] <= writebacks[i][36:5];
        end
      end

      retiredUpper   <= retireUpper ? retirePayload(entryStore[head], entryDest[head], entryResult[head]) : '0;
      retiredLower   <= retireLower ? retirePayload(1'b0, entryDest[headNext], entryResult[headNext]) : '0;
      storeCommit    <= retireUpper && entryStore[head];
      storeCommitTag <= (retireUpper && entryStore[head]) ? entryTag[head] : '0;
      if (retireUpper) begin
        entryValid[head] <= 1'b0;
        entryReady[head] <= 1'b0;
      end
      if (retireLower) begin
        entryValid[headNext] <= 1'b0;
        entryReady[headNext] <= 1'b0;
      end

      // Allocation only targets free slots, so it never overlaps a retiring entry.
      if (acceptUpper) begin
        entryValid[tail] <= 1'b1;
        entryReady[tail] <= 1'b0;
        entryStore[tail] <= upStore;
        entryTag[tail]   <= upTag;
        entryDest[tail]  <= upDest;
        entryPc[tail]    <= upPc;
      end
      if (acceptLower) begin
        entryValid[lowerSlot] <= 1'b1;
        entryReady[lowerSlot] <= 1'b0;
        entryStore[lowerSlot] <= loStore;
        entryTag[lowerSlot]   <= loTag;
        entryDest[lowerSlot]  <= loDest;
        entryPc[lowerSlot]    <= loPc;
      end

      head  <= head + retireCount[TAG_W-1:0];
      tail  <= tail + allocCount[TAG_W-1:0];
      count <= count + allocCount - retireCount;
    end
  end

`ifdef ROB_PROTOCOL_CHECK_EN
  logic protoViolation;

  always_comb begin
    protoViolation = 1'b0;
    if (upConfirm && !acceptUpper) protoViolation = 1'b1;
    if (loConfirm && !acceptLower) protoViolation = 1'b1;
    if (acceptUpper && upTag != tail) protoViolation = 1'b1;
    if (acceptLower && loTag != lowerSlot) protoViolation = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (writebacks[i][0] && !entryValid[writebacks[i][4:1]]) protoViolation = 1'b1;
      for (int j = i + 1; j < 3; j++) begin
        if (writebacks[i][0] && writebacks[j][0] && writebacks[i][4:1] == writebacks[j][4:1])
          protoViolation = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) protocolError <= 1'b0;
    else        protocolError <= protocolError | protoViolation;
  end
`endif

endmodule
